// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: TMS-driven 16-state FSM, IR/DR strobes and the
// latched instruction.  Every output is a flop loaded from a decode of the next state.
module tap_controller #(
   parameter int                  IR_WIDTH     = 4,
   parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = 4'b0001
) (
   input  logic                tck,
   input  logic                trst,
   input  logic                tms,
   input  logic [IR_WIDTH-1:0] ir_shift,
   output logic [3:0]          state,
   output logic                tlr,
   output logic                capture_ir,
   output logic                shift_ir,
   output logic                update_ir,
   output logic                capture_dr,
   output logic                shift_dr,
   output logic                update_dr,
   output logic                ir_enable,
   output logic                select_ir,
   output logic                tdo_en,
   output logic [IR_WIDTH-1:0] instr
);

   typedef enum logic [3:0] {
      TLR      = 4'hF, RTI      = 4'hC,
      SEL_DR   = 4'h7, CAP_DR   = 4'h6, SH_DR    = 4'h2, EX1_DR   = 4'h1,
      PAUSE_DR = 4'h3, EX2_DR   = 4'h0, UPD_DR   = 4'h5,
      SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR    = 4'hA, EX1_IR   = 4'h9,
      PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR   = 4'hD
   } tap_state_e;

   // Output vector bit order:
   // {tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr, ir_enable, select_ir, tdo_en}
   function automatic logic [9:0] decode(input tap_state_e s);
      logic [9:0] d;
      d = 10'b0;
      case (s)
         TLR:      d[9] = 1'b1;
         CAP_IR:   begin d[8] = 1'b1; d[2] = 1'b1; d[1] = 1'b1; end
         SH_IR:    begin d[7] = 1'b1; d[2] = 1'b1; d[1] = 1'b1; d[0] = 1'b1; end
         UPD_IR:   begin d[6] = 1'b1; d[1] = 1'b1; end
         SEL_IR, EX1_IR, PAUSE_IR, EX2_IR: d[1] = 1'b1;
         CAP_DR:   d[5] = 1'b1;
         SH_DR:    begin d[4] = 1'b1; d[0] = 1'b1; end
         UPD_DR:   d[3] = 1'b1;
         default:  d = 10'b0;
      endcase
      return d;
   endfunction

   tap_state_e          state_q, state_d;
   logic [9:0]          outs_q, outs_d;
   logic [IR_WIDTH-1:0] instr_q, instr_d;

   // Next-state, next-output and next-instruction computation.
   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:      state_d = tms ? TLR      : RTI;
         RTI:      state_d = tms ? SEL_DR   : RTI;
         SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
         CAP_DR:   state_d = tms ? EX1_DR   : SH_DR;
         SH_DR:    state_d = tms ? EX1_DR   : SH_DR;
         EX1_DR:   state_d = tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: state_d = tms ? EX2_DR   : PAUSE_DR;
         EX2_DR:   state_d = tms ? UPD_DR   : SH_DR;
         UPD_DR:   state_d = tms ? SEL_DR   : RTI;
         SEL_IR:   state_d = tms ? TLR      : CAP_IR;
         CAP_IR:   state_d = tms ? EX1_IR   : SH_IR;
         SH_IR:    state_d = tms ? EX1_IR   : SH_IR;
         EX1_IR:   state_d = tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: state_d = tms ? EX2_IR   : PAUSE_IR;
         EX2_IR:   state_d = tms ? UPD_IR   : SH_IR;
         UPD_IR:   state_d = tms ? SEL_DR   : RTI;
         default:  state_d = TLR;
      endcase

      outs_d = decode(state_d);

      if (state_q == UPD_IR) begin
         instr_d = ir_shift;
      end else if (state_q == TLR) begin
         instr_d = IDCODE_INSTR;
      end else begin
         instr_d = instr_q;
      end
   end

   // State, decoded outputs and instruction registers; trst overrides everything.
   always_ff @(posedge tck) begin
      if (trst) begin
         state_q <= TLR;
         outs_q  <= decode(TLR);
         instr_q <= IDCODE_INSTR;
      end else begin
         state_q <= state_d;
         outs_q  <= outs_d;
         instr_q <= instr_d;
      end
   end

   assign state = state_q;
   assign {tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr,
           update_dr, ir_enable, select_ir, tdo_en} = outs_q;
   assign instr = instr_q;

endmodule

// File: doc/tap_controller.md
Name: tap_controller

Overview:
- IEEE 1149.1 TAP state machine that sequences the JTAG instruction register and the data registers.
- Decodes TMS into the 16 TAP states and produces capture/shift/update strobes for the IR and DR chains.
- Holds the latched (update-stage) instruction, loaded from the IR shift chain in Update-IR and forced to IDCODE in Test-Logic-Reset.
- Sits between the chip-level TAP pins and the instruction register, data registers and TDO mux.

Parameters:
IR_WIDTH, 4, width of instruction register and latched instruction
IDCODE_INSTR, 4'b0001, instruction loaded on reset and in Test-Logic-Reset (IR_WIDTH bits)

Ports:
tck  input  1  TAP clock; all state updates on rising edge
trst  input  1  synchronous, active-high reset (sampled on rising tck)
tms  input  1  test mode select
ir_shift  input  IR_WIDTH  parallel contents of the IR shift chain
state  output  4  current TAP state, encoding below
tlr  output  1  high in Test-Logic-Reset
capture_ir  output  1  high in Capture-IR
shift_ir  output  1  high in Shift-IR
update_ir  output  1  high in Update-IR
capture_dr  output  1  high in Capture-DR
shift_dr  output  1  high in Shift-DR
update_dr  output  1  high in Update-DR
ir_enable  output  1  IR chain shift/load enable = capture_ir | shift_ir
select_ir  output  1  TDO mux select: high in Select-IR-Scan through Update-IR
tdo_en  output  1  high in Shift-IR or Shift-DR
instr  output  IR_WIDTH  latched instruction

Behaviour:
- Clock and reset: one clock, tck. trst is synchronous and active-high.
- Reset: when trst = 1 at a rising tck edge, state <= TLR and instr <= IDCODE_INSTR. All outputs then take their TLR-decode values:
  - tlr = 1.
  - All strobes, ir_enable, select_ir and tdo_en = 0.
- trst has priority over tms. Reset mid-scan abandons the scan: instr is not updated from ir_shift.
- State encoding (hex):
  - TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAUSE_DR=3, EX2_DR=0, UPD_DR=5
  - SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAUSE_IR=B, EX2_IR=8, UPD_IR=D
- Transitions on rising tck, written as (tms=0 / tms=1):
  - TLR: RTI / TLR; RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR; SEL_IR: CAP_IR / TLR
  - CAP_x: SH_x / EX1_x; SH_x: SH_x / EX1_x
  - EX1_x: PAUSE_x / UPD_x; PAUSE_x: PAUSE_x / EX2_x
  - EX2_x: SH_x / UPD_x; UPD_x: RTI / SEL_DR
- From any state, 5 consecutive tms=1 edges reach TLR.
- Output decode:
  - All strobe and select outputs are combinational decodes of the state register only, never of tms. They are glitch-free relative to the state register.
  - Each strobe is high for exactly the cycles the FSM is in its state. Shift strobes stay high across consecutive SH cycles.
- Instruction latch:
  - On a rising tck edge with state == UPD_IR: instr <= ir_shift. The new value is visible from the next cycle onward.
  - On a rising tck edge with state == TLR: instr <= IDCODE_INSTR.
  - In all other states instr holds. Changes in instr occur only after UPD_IR or TLR.
- Latency:
  - state is visible 1 cycle after the edge that samples tms.
  - instr is visible 1 cycle after leaving UPD_IR.
- No X propagation: an unknown tms is not a legal stimulus. state must never take an encoding outside the 16 listed.

Test Plan:
- Reset: trst=1 for 1 edge with any tms -> state=F, tlr=1, instr=0001, all strobes 0. Then tms=0 -> state=C.
- IR scan: from RTI, tms sequence 1,1,0,0,0,0,0,1,1,0 with ir_shift=4'b1010 held -> states 7,4,E,A,A,A,A,9,D,C.
  - capture_ir high 1 cycle; shift_ir high 4 cycles; ir_enable high 5 cycles; select_ir high from state 4 through D.
  - instr=1010 from the cycle state=C.
- DR scan with pause: from RTI, tms 1,0,0,1,0,0,1,0,1,1 -> states 7,6,2,1,3,3,0,2,1,5.
  - shift_dr and tdo_en high in state 2 only; update_dr pulses once in state 5; instr unchanged.
- TLR from anywhere: for each of the 16 states, apply tms=1 for 5 edges -> state=F. A latched instr of 1010 returns to 0001 on the first edge taken in TLR.
- Reset mid-scan: in SH_IR with ir_shift=1111, assert trst for 1 edge -> state=F, instr=0001, no UPD_IR seen. Then tms=0 -> RTI.
- Hold states: tms=0 for 10 edges in each of RTI, SH_DR, PAUSE_IR -> state constant, strobes constant, instr unchanged.
